// File: rtl/ntm_values_vector_adder.sv
// ntm_values_vector_adder
//   Sequential element-wise adder/subtractor for the NTM values-vector path.
//   A vector of SIZE_I unsigned element pairs (A, B) is streamed in after a
//   start handshake; each accepted pair yields one registered DATA_SIZE+1 bit
//   result tagged with its element index. mode is latched at start.
//
//   state          | meaning
//   ---------------+--------------------------------------------------
//   STARTER_STATE  | idle, ready=1, waiting for start
//   INPUT_STATE    | collecting element pairs, ready=0
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   start           begin a vector (honoured only while ready=1)
//   mode            0 = A+B, 1 = A-B; sampled on accepted start
//   data_in_enable  data_a_in/data_b_in pair valid
//   data_a_in       operand A element (unsigned)
//   data_b_in       operand B element (unsigned)
//   ready           idle, will accept start
//   data_out_enable one-cycle strobe, data_out/data_out_index valid
//   data_out        result element (MSB = carry for add, borrow for sub)
//   data_out_index  element index of data_out
//   done            one-cycle pulse coincident with the last result

module ntm_values_vector_adder #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_I     = 4,
  parameter int INDEX_SIZE = (SIZE_I > 1) ? $clog2(SIZE_I) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  data_in_enable,
  input  logic [DATA_SIZE-1:0]  data_a_in,
  input  logic [DATA_SIZE-1:0]  data_b_in,
  output logic                  ready,
  output logic                  data_out_enable,
  output logic [DATA_SIZE:0]    data_out,
  output logic [INDEX_SIZE-1:0] data_out_index,
  output logic                  done
);

  localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(SIZE_I - 1);

  typedef enum logic {
    STARTER_STATE = 1'b0,
    INPUT_STATE   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_SIZE-1:0] cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  accept;
  logic                  last;
  logic [DATA_SIZE:0]    result;

  // Operands are zero-extended; subtraction wraps modulo 2^(DATA_SIZE+1)
  // so the MSB reads as the borrow.
  always_comb begin
    result = '0;
    if (mode_q) result = {1'b0, data_a_in} - {1'b0, data_b_in};
    else        result = {1'b0, data_a_in} + {1'b0, data_b_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STARTER_STATE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      STARTER_STATE: begin
        // data_in_enable is deliberately ignored here, even alongside start.
        if (start) begin
          state_d = INPUT_STATE;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      INPUT_STATE: begin
        if (data_in_enable) begin
          accept = 1'b1;
          if (cnt_q == LAST_IDX) begin
            last    = 1'b1;
            state_d = STARTER_STATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + INDEX_SIZE'(1);
          end
        end
      end
      default: state_d = STARTER_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_enable <= 1'b0;
      data_out        <= '0;
      data_out_index  <= '0;
      done            <= 1'b0;
    end else begin
      data_out_enable <= accept;
      done            <= last;
      if (accept) begin
        data_out       <= result;
        data_out_index <= cnt_q;
      end
    end
  end

  // Derived from the state flop only, so ready stays free of input paths.
  assign ready = (state_q == STARTER_STATE);

endmodule

// File: doc/ntm_values_vector_adder.md
# ntm_values_vector_adder

Sequential, parametrised element-wise adder/subtractor for the transformer values-vector input path. It accepts two operand streams, element A and element B, one element pair per enabled cycle, for a vector of `SIZE_I` elements. Each pair produces one registered `DATA_SIZE+1`-bit result tagged with its element index. Handshaking is start/ready/done, so the block slots in front of the NTM values-vector consumers in place of the fixed 8-bit combinational adder.

## Interface

Parameters:
- `DATA_SIZE`, default 8: operand width in bits.
- `SIZE_I`, default 4: elements per vector, ≥ 1.
- `INDEX_SIZE`, default `$clog2(SIZE_I)` (minimum 1): index width.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a vector operation; honoured only while `ready`=1.
- `mode`  in  1  0 = add, 1 = subtract (A−B); sampled on accepted `start`.
- `data_in_enable`  in  1  the current `data_a_in`/`data_b_in` pair is valid.
- `data_a_in`  in  `DATA_SIZE`  operand A element, unsigned.
- `data_b_in`  in  `DATA_SIZE`  operand B element, unsigned.
- `ready`  out  1  block is idle and will accept `start`.
- `data_out_enable`  out  1  one-cycle strobe; `data_out`/`data_out_index` are valid.
- `data_out`  out  `DATA_SIZE+1`  result element.
- `data_out_index`  out  `INDEX_SIZE`  element index of `data_out`, 0..`SIZE_I`−1.
- `done`  out  1  one-cycle pulse coincident with the last result.

## Operation

- FSM states:
  - **STARTER_STATE** (idle). `ready`=1.
  - **INPUT_STATE** (collecting elements). `ready`=0.
- STARTER → INPUT on `start`=1. At that edge: latch `mode`, clear the element counter to 0.
- In INPUT_STATE, each cycle with `data_in_enable`=1 accepts one pair:
  - compute the result;
  - register the result and the current counter value;
  - increment the counter.
- `data_in_enable`=0 in INPUT_STATE stalls the block: no output, counter unchanged, no timeout.
- Accepting the pair at counter = `SIZE_I`−1 returns the FSM to STARTER_STATE at the same edge.
- Arithmetic, with operands zero-extended to `DATA_SIZE+1` bits:
  - add: `{0,A}+{0,B}`; this never overflows;
  - subtract: `{0,A}−{0,B}` modulo 2^(`DATA_SIZE+1`), so the MSB is the borrow/sign.
- The latched mode is used for the whole vector; `mode` changes after `start` are ignored.
- `start` while `ready`=0 is ignored.
- `data_in_enable` while in STARTER_STATE is ignored, including in the same cycle as `start`. The first element can be accepted no earlier than the cycle after `start`.
- `data_out` and `data_out_index` hold their last values while `data_out_enable`=0.
- `SIZE_I`=1: a single accepted pair ends the vector; `done` fires with that result.

## Timing

- Reset values (asserted asynchronously while `rst`=0):
  - FSM = STARTER_STATE, counter = 0, latched mode = 0;
  - `ready`=1, `data_out_enable`=0, `data_out`=0, `data_out_index`=0, `done`=0.
- Reset mid-vector aborts the operation. Partial results are discarded and there is no `done`. After `rst` deasserts the block is idle, with `ready`=1 on the first clock.
- `start` accepted at edge N:
  - `ready`=0 from N;
  - the earliest element is accepted at edge N+1.
- Element accepted at edge K:
  - `data_out_enable`=1, `data_out`, `data_out_index` are valid after edge K, for exactly one cycle;
  - latency is 1 cycle;
  - throughput is 1 element per cycle.
- Last element accepted at edge L:
  - `done`=1 and `data_out_enable`=1 for the same cycle after L;
  - `ready`=1 after L, so a new `start` can be accepted at edge L+1;
  - back-to-back vectors lose one cycle per vector (the start cycle).
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Reset check** (defaults). Hold `rst`=0 with random inputs toggling → `ready`=1, `done`=0, `data_out_enable`=0, `data_out`=0, `data_out_index`=0 throughout.
- **Add vector** (defaults, mode=0). `start`, then A={1,255,128,0}, B={2,255,128,0} on consecutive cycles → results 0x003, 0x1FE, 0x100, 0x000 with indices 0..3. `done` is high with index 3 only; `ready` rises the same cycle.
- **Subtract with stalls** (mode=1). A={3,10}, B={5,10} with `data_in_enable` gaps of 2 cycles, `SIZE_I`=2 → results 0x1FE, 0x000. No output strobes during the gaps. Toggling `mode` mid-vector has no effect.
- **Ignored inputs**:
  - `data_in_enable`=1 with A=B=7 in the same cycle as `start` → no output that cycle; the first result comes from the next pair.
  - `start` pulsed mid-vector → no restart; the counter continues.
- **Reset mid-operation**. Assert `rst` after 2 of 4 elements → outputs clear immediately and no `done` is produced. A following full vector produces indices starting at 0.
- **Back-to-back and `SIZE_I`=1**:
  - `start` at L+1 after `done` → second vector accepted.
  - With `SIZE_I`=1, A=200, B=100, mode=0 → `data_out`=0x12C with `done` in the same cycle.
